// File: rtl/rc_add_sub_serial.sv
// rc_add_sub_serial: multi-cycle chunked add/subtract with carry-out and signed overflow
//
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock through a
// registered carry, so a result appears WIDTH/CHUNK cycles after the operands
// are accepted.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits processed per cycle (WIDTH must be a multiple of CHUNK)
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous reset, active-low
//   IN_VALID   operand request
//   IN_READY   operands accepted (IDLE only, low while in reset)
//   A, B       operands
//   SnA        0 = add, 1 = subtract
//   OUT_VALID  result valid (DONE only)
//   OUT_READY  consumer accepts result
//   Y          registered result
//   CO         carry out of the MSB (subtract: 1 = no borrow)
//   OVF        signed overflow
//   BUSY       high while chunks are being processed
//
// Optional feature: define RC_ADD_SUB_SAT_EN to saturate Y to the signed
// limit of the operand sign whenever OVF is raised.
module rc_add_sub_serial #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SnA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             OVF,
    output logic             BUSY
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = NCH > 1 ? $clog2(NCH) : 1;

    if (WIDTH < 2 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_param
        $error("rc_add_sub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d, co_q, co_d, ovf_q, ovf_d;
    logic [CHUNK-1:0] a_ch, b_ch, sum;
    logic             c_out, c_msb, last;

    always_comb begin
        a_ch           = a_q[int'(k_q)*CHUNK +: CHUNK];
        b_ch           = b_q[int'(k_q)*CHUNK +: CHUNK];
        {c_out, sum}   = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // carry into the MSB recovered from its sum bit: s = a ^ b ^ cin
        c_msb          = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum[CHUNK-1];
        last           = k_q == KW'(NCH - 1);
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        y_d            = y_q;
        k_d            = k_q;
        carry_d        = carry_q;
        co_d           = co_q;
        ovf_d          = ovf_q;
        case (state_q)
            IDLE: if (IN_VALID) begin
                a_d     = A;
                b_d     = B ^ {WIDTH{SnA}};
                carry_d = SnA;
                k_d     = '0;
                y_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                y_d[int'(k_q)*CHUNK +: CHUNK] = sum;
                carry_d = c_out;
                k_d     = k_q + 1'b1;
                if (last) begin
                    co_d    = c_out;
                    ovf_d   = c_out ^ c_msb;
                    state_d = DONE;
`ifdef RC_ADD_SUB_SAT_EN
                    if (c_out ^ c_msb)
                        y_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                end
            end
            DONE: if (OUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // IN_READY is gated by reset so every output reads 0 while RST is held
    assign IN_READY  = (state_q == IDLE) && RST;
    assign OUT_VALID = state_q == DONE;
    assign BUSY      = state_q == RUN;
    assign Y         = y_q;
    assign CO        = co_q;
    assign OVF       = ovf_q;
endmodule
